// File: rtl/simplerisc_pkg.sv
// ----------------------------------------------------------------------------
// simplerisc_pkg: SimpleRISC opcodes, field positions and MDU state encoding
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package simplerisc_pkg;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int IMM_BIT = 26;
  localparam int RD_MSB  = 25;
  localparam int RD_LSB  = 22;
  localparam int RS1_MSB = 21;
  localparam int RS1_LSB = 18;
  localparam int RS2_MSB = 17;
  localparam int RS2_LSB = 14;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_DIV  = 5'b00011;
  localparam logic [4:0] OP_MOD  = 5'b00100;
  localparam logic [4:0] OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_MOV  = 5'b01001;
  localparam logic [4:0] OP_ASR  = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b01101;
  localparam logic [4:0] OP_LD   = 5'b01110;
  localparam logic [4:0] OP_ST   = 5'b01111;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BGT  = 5'b10001;
  localparam logic [4:0] OP_B    = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;

  localparam logic [3:0] RA_IDX = 4'hF;

  typedef enum logic [0:0] {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_t;

endpackage

`default_nettype wire

// File: rtl/hazard_src_decode.sv
// ----------------------------------------------------------------------------
// hazard_src_decode: register sources read by an instruction, with valid bits
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hazard_src_decode
  import simplerisc_pkg::*;
(
  input  logic       valid,
  input  logic [4:0] opcode,
  input  logic       imm,
  input  logic [3:0] rd,
  input  logic [3:0] rs1,
  input  logic [3:0] rs2,
  output logic [3:0] src1,
  output logic       src1_valid,
  output logic [3:0] src2,
  output logic       src2_valid,
  output logic [3:0] src3,
  output logic       src3_valid
);

  always_comb begin
    src1       = rs1;
    src1_valid = valid;
    case (opcode)
      OP_NOP, OP_NOT, OP_MOV, OP_B, OP_BEQ, OP_BGT, OP_CALL: src1_valid = 1'b0;
      OP_RET:  src1 = RA_IDX;
      default: ;
    endcase

    // Register-form ALU ops; not/mov take their single register operand here
    src2       = rs2;
    src2_valid = valid && !imm && (opcode <= OP_ASR);

    // Store data comes from the rd field
    src3       = rd;
    src3_valid = valid && (opcode == OP_ST);
  end

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_controller: SimpleRISC interlocks, MDU sequencing, perf counters
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pipeline_hazard_controller
  import simplerisc_pkg::*;
#(
  parameter int DIV_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      of_instr,
  input  logic             of_valid,
  input  logic [31:0]      ex_instr,
  input  logic             ex_valid,
  input  logic             ex_branch_taken,
  output logic             stall_pc,
  output logic             stall_if_of,
  output logic             stall_of_ex,
  output logic             bubble_of_ex,
  output logic             bubble_ex_ma,
  output logic             flush_if_of,
  output logic             mdu_start,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 2);

  logic [3:0] src1, src2, src3;
  logic       src1_valid, src2_valid, src3_valid;
  logic [4:0] ex_opcode;
  logic [3:0] ex_rd;
  logic       ex_divmod;
  logic       load_use_raw, load_use, branch;
  logic       unused_instr_bits;

  mdu_state_t state, state_next;
  logic [3:0] cnt, cnt_next;
  logic       mdu_stall, mdu_active, start;

  hazard_src_decode u_of_decode (
    .valid      (of_valid),
    .opcode     (of_instr[OPC_MSB:OPC_LSB]),
    .imm        (of_instr[IMM_BIT]),
    .rd         (of_instr[RD_MSB:RD_LSB]),
    .rs1        (of_instr[RS1_MSB:RS1_LSB]),
    .rs2        (of_instr[RS2_MSB:RS2_LSB]),
    .src1       (src1),
    .src1_valid (src1_valid),
    .src2       (src2),
    .src2_valid (src2_valid),
    .src3       (src3),
    .src3_valid (src3_valid)
  );

  assign ex_opcode = ex_instr[OPC_MSB:OPC_LSB];
  assign ex_rd     = ex_instr[RD_MSB:RD_LSB];
  assign ex_divmod = ex_valid && ((ex_opcode == OP_DIV) || (ex_opcode == OP_MOD));
  assign unused_instr_bits = ^{of_instr[RS2_LSB-1:0], ex_instr[IMM_BIT], ex_instr[RS1_MSB:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= MDU_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    mdu_stall  = 1'b0;
    mdu_active = 1'b0;
    start      = 1'b0;
    case (state)
      MDU_IDLE: begin
        if (ex_divmod) begin
          start      = 1'b1;
          mdu_active = 1'b1;
          mdu_stall  = 1'b1;
          state_next = MDU_BUSY;
          cnt_next   = DIV_LOAD;
        end
      end
      MDU_BUSY: begin
        mdu_active = 1'b1;
        // Final cycle: the div/mod is released to MA at this edge
        if (cnt != 4'd0) begin
          mdu_stall = 1'b1;
          cnt_next  = cnt - 4'd1;
        end else begin
          state_next = MDU_IDLE;
        end
      end
      default: state_next = MDU_IDLE;
    endcase
  end

  assign load_use_raw = ex_valid && (ex_opcode == OP_LD) &&
                        ((src1_valid && (src1 == ex_rd)) ||
                         (src2_valid && (src2 == ex_rd)) ||
                         (src3_valid && (src3 == ex_rd)));

  assign branch   = ex_valid && ex_branch_taken && !mdu_stall;
  assign load_use = load_use_raw && !mdu_stall && !branch;

  // Controls are forced low while reset is held so nothing leaks out mid-reset
  assign stall_pc     = reset_n && (mdu_stall || load_use);
  assign stall_if_of  = reset_n && (mdu_stall || load_use);
  assign stall_of_ex  = reset_n && mdu_stall;
  assign bubble_of_ex = reset_n && (branch || load_use);
  assign bubble_ex_ma = reset_n && mdu_stall;
  assign flush_if_of  = reset_n && branch;
  assign mdu_start    = reset_n && start;
  assign mdu_busy     = reset_n && mdu_active;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_pc && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + CNT_W'(1);
      if (flush_if_of && (flush_count != {CNT_W{1'b1}}))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
// ----------------------------------------------------------------------------
// tb_pipeline_hazard_controller: directed and randomized checks against a reference model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pipeline_hazard_controller;

  localparam int DIV_CYCLES = 4;
  localparam int CNT_W      = 16;
  localparam int SAT_W      = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] of_instr = '0;
  logic        of_valid = 1'b0;
  logic [31:0] ex_instr = '0;
  logic        ex_valid = 1'b0;
  logic        ex_branch_taken = 1'b0;

  logic stall_pc, stall_if_of, stall_of_ex, bubble_of_ex, bubble_ex_ma, flush_if_of, mdu_start, mdu_busy;
  logic [CNT_W-1:0] stall_count, flush_count;
  logic s_stall_pc, s_stall_if_of, s_stall_of_ex, s_bubble_of_ex, s_bubble_ex_ma, s_flush_if_of, s_mdu_start, s_mdu_busy;
  logic [SAT_W-1:0] s_stall_count, s_flush_count;
  logic [7:0] ctrl;

  int checks = 0;
  int errors = 0;
  int age = 0;
  int exp_stall = 0, exp_flush = 0, exp_sat_stall = 0, exp_sat_flush = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .of_instr(of_instr), .of_valid(of_valid),
    .ex_instr(ex_instr), .ex_valid(ex_valid), .ex_branch_taken(ex_branch_taken),
    .stall_pc(stall_pc), .stall_if_of(stall_if_of), .stall_of_ex(stall_of_ex),
    .bubble_of_ex(bubble_of_ex), .bubble_ex_ma(bubble_ex_ma), .flush_if_of(flush_if_of),
    .mdu_start(mdu_start), .mdu_busy(mdu_busy), .stall_count(stall_count), .flush_count(flush_count)
  );

  pipeline_hazard_controller #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(SAT_W)) dut_sat (
    .clk(clk), .reset_n(reset_n), .of_instr(of_instr), .of_valid(of_valid),
    .ex_instr(ex_instr), .ex_valid(ex_valid), .ex_branch_taken(ex_branch_taken),
    .stall_pc(s_stall_pc), .stall_if_of(s_stall_if_of), .stall_of_ex(s_stall_of_ex),
    .bubble_of_ex(s_bubble_of_ex), .bubble_ex_ma(s_bubble_ex_ma), .flush_if_of(s_flush_if_of),
    .mdu_start(s_mdu_start), .mdu_busy(s_mdu_busy), .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  assign ctrl = {stall_pc, stall_if_of, stall_of_ex, bubble_of_ex, bubble_ex_ma, flush_if_of, mdu_start, mdu_busy};

  function automatic logic [31:0] enc(input logic [4:0] op, input logic imm, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2);
    return {op, imm, rd, rs1, rs2, 14'h0};
  endfunction

  // Which registers an instruction reads, by instruction class
  function automatic bit reads_reg(input logic [31:0] ins, input logic [3:0] r);
    logic [4:0] op;
    logic       imm;
    logic [3:0] rd, rs1, rs2;
    op = ins[31:27]; imm = ins[26]; rd = ins[25:22]; rs1 = ins[21:18]; rs2 = ins[17:14];
    case (op)
      5'd13, 5'd16, 5'd17, 5'd18, 5'd19: return 1'b0;
      5'd8, 5'd9: return !imm && (rs2 == r);
      5'd20: return r == 4'hF;
      5'd14: return rs1 == r;
      5'd15: return (rs1 == r) || (rd == r);
      default: begin
        if (op <= 5'd12) return (rs1 == r) || (!imm && (rs2 == r));
        return rs1 == r;
      end
    endcase
  endfunction

  // Expected {stall_pc, stall_if_of, stall_of_ex, bubble_of_ex, bubble_ex_ma, flush_if_of, mdu_start, mdu_busy};
  // a = cycles the current div/mod has already spent in EX
  function automatic logic [7:0] exp_ctrl(input logic [31:0] of_i, input logic ofv, input logic [31:0] ex_i,
                                          input logic exv, input logic bt, input int a, input logic rn);
    logic divmod, active, mstall, lu, br, stl;
    if (!rn) return 8'h00;
    divmod = exv && ((ex_i[31:27] == 5'd3) || (ex_i[31:27] == 5'd4));
    active = (a > 0) || divmod;
    mstall = active && (a < DIV_CYCLES - 1);
    br     = exv && bt && !mstall;
    lu     = exv && (ex_i[31:27] == 5'd14) && ofv && reads_reg(of_i, ex_i[25:22]) && !mstall && !br;
    stl    = mstall || lu;
    return {stl, stl, mstall, br || lu, mstall, br, active && (a == 0), active};
  endfunction

  function automatic logic [3:0] rreg();
    return ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3));
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] op;
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 3)       op = 5'd14;
    else if (sel == 3) op = ($urandom_range(0, 1) == 0) ? 5'd3 : 5'd4;
    else               op = 5'($urandom_range(0, 31));
    return {op, 1'($urandom_range(0, 1)), rreg(), rreg(), rreg(), 14'($urandom)};
  endfunction

  task automatic set_in(input logic [31:0] of_i, input logic ofv, input logic [31:0] ex_i,
                        input logic exv, input logic bt);
    of_instr = of_i; of_valid = ofv; ex_instr = ex_i; ex_valid = exv; ex_branch_taken = bt;
  endtask

  // Advance one clock and update the reference model's state
  task automatic tick();
    logic [7:0] e;
    logic divmod;
    e = exp_ctrl(of_instr, of_valid, ex_instr, ex_valid, ex_branch_taken, age, reset_n);
    divmod = ex_valid && ((ex_instr[31:27] == 5'd3) || (ex_instr[31:27] == 5'd4));
    @(posedge clk);
    if (reset_n) begin
      if (e[7]) begin
        if (exp_stall < (1 << CNT_W) - 1) exp_stall++;
        if (exp_sat_stall < (1 << SAT_W) - 1) exp_sat_stall++;
      end
      if (e[2]) begin
        if (exp_flush < (1 << CNT_W) - 1) exp_flush++;
        if (exp_sat_flush < (1 << SAT_W) - 1) exp_sat_flush++;
      end
      if ((age > 0) || divmod) age = (age + 1 == DIV_CYCLES) ? 0 : age + 1;
    end
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    set_in('0, 1'b0, '0, 1'b0, 1'b0);
    age = 0; exp_stall = 0; exp_flush = 0; exp_sat_stall = 0; exp_sat_flush = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_in(enc(5'd0, 1'b0, 4'd4, 4'd3, 4'd2), 1'b1, enc(5'd3, 1'b0, 4'd3, 4'd1, 4'd1), 1'b1, 1'b1);
    #1;
    checks++;
    if (ctrl !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %b expected %b", ctrl, 8'h00); end
    checks++;
    if (stall_count !== '0 || flush_count !== '0) begin
      errors++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", stall_count, flush_count);
    end
    do_reset();
  endtask

  task automatic test_load_use();
    logic [31:0] ld_r3;
    do_reset();
    ld_r3 = enc(5'd14, 1'b1, 4'd3, 4'd1, 4'd0);
    set_in(enc(5'd0, 1'b0, 4'd4, 4'd3, 4'd2), 1'b1, ld_r3, 1'b1, 1'b0);
    #1;
    checks++;
    if (ctrl !== 8'b1101_0000) begin errors++; $display("FAIL load_use_ctrl: got %b expected %b", ctrl, 8'b1101_0000); end
    tick();
    checks++;
    if (stall_count !== 16'd1) begin errors++; $display("FAIL load_use_count: got %0d expected 1", stall_count); end
    ex_valid = 1'b0;
    #1;
    checks++;
    if (ctrl !== 8'h00) begin errors++; $display("FAIL load_use_once: got %b expected %b", ctrl, 8'h00); end
    tick();
    checks++;
    if (stall_count !== 16'd1) begin errors++; $display("FAIL load_use_count2: got %0d expected 1", stall_count); end
    // store data, ret through ra, and a branch whose rs1 field happens to match
    set_in(enc(5'd15, 1'b1, 4'd3, 4'd6, 4'd0), 1'b1, ld_r3, 1'b1, 1'b0);
    #1;
    checks++;
    if (ctrl !== 8'b1101_0000) begin errors++; $display("FAIL load_use_st: got %b expected %b", ctrl, 8'b1101_0000); end
    set_in(enc(5'd20, 1'b0, 4'd0, 4'd0, 4'd0), 1'b1, enc(5'd14, 1'b1, 4'hF, 4'd1, 4'd0), 1'b1, 1'b0);
    #1;
    checks++;
    if (ctrl !== 8'b1101_0000) begin errors++; $display("FAIL load_use_ret: got %b expected %b", ctrl, 8'b1101_0000); end
    set_in(enc(5'd16, 1'b0, 4'd3, 4'd3, 4'd3), 1'b1, ld_r3, 1'b1, 1'b0);
    #1;
    checks++;
    if (ctrl !== 8'h00) begin errors++; $display("FAIL load_use_beq: got %b expected %b", ctrl, 8'h00); end
  endtask

  task automatic test_no_hazard();
    do_reset();
    set_in(enc(5'd0, 1'b1, 4'd4, 4'd1, 4'd3), 1'b1, enc(5'd14, 1'b1, 4'd3, 4'd1, 4'd0), 1'b1, 1'b0);
    #1;
    checks++;
    if (ctrl !== 8'h00) begin errors++; $display("FAIL no_hazard_imm: got %b expected %b", ctrl, 8'h00); end
    set_in(enc(5'd0, 1'b0, 4'd4, 4'd3, 4'd3), 1'b0, enc(5'd14, 1'b1, 4'd3, 4'd1, 4'd0), 1'b1, 1'b0);
    #1;
    checks++;
    if (ctrl !== 8'h00) begin errors++; $display("FAIL no_hazard_of_bubble: got %b expected %b", ctrl, 8'h00); end
  endtask

  task automatic test_branch();
    do_reset();
    set_in(enc(5'd0, 1'b0, 4'd6, 4'd5, 4'd5), 1'b1, enc(5'd16, 1'b0, 4'd0, 4'd0, 4'd0), 1'b1, 1'b1);
    #1;
    checks++;
    if (ctrl !== 8'b0001_0100) begin errors++; $display("FAIL branch_ctrl: got %b expected %b", ctrl, 8'b0001_0100); end
    tick();
    checks++;
    if (flush_count !== 16'd1 || stall_count !== 16'd0) begin
      errors++; $display("FAIL branch_counts: got flush %0d stall %0d expected 1/0", flush_count, stall_count);
    end
    // taken-branch signal alongside a load-use match: branch wins, PC not held
    set_in(enc(5'd0, 1'b0, 4'd6, 4'd5, 4'd5), 1'b1, enc(5'd14, 1'b1, 4'd5, 4'd1, 4'd0), 1'b1, 1'b1);
    #1;
    checks++;
    if (ctrl !== 8'b0001_0100) begin errors++; $display("FAIL branch_priority: got %b expected %b", ctrl, 8'b0001_0100); end
    ex_valid = 1'b0;
    #1;
    checks++;
    if (ctrl !== 8'h00) begin errors++; $display("FAIL branch_invalid: got %b expected %b", ctrl, 8'h00); end
  endtask

  task automatic test_divide();
    logic [7:0] seq [4];
    seq[0] = 8'b1110_1011; seq[1] = 8'b1110_1001; seq[2] = 8'b1110_1001; seq[3] = 8'b0000_0001;
    do_reset();
    set_in(enc(5'd0, 1'b0, 4'd5, 4'd2, 4'd2), 1'b1, enc(5'd3, 1'b0, 4'd2, 4'd3, 4'd4), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (ctrl !== seq[i]) begin errors++; $display("FAIL divide_cycle%0d: got %b expected %b", i, ctrl, seq[i]); end
      tick();
    end
    ex_instr = enc(5'd13, 1'b0, 4'd0, 4'd0, 4'd0);
    #1;
    checks++;
    if (ctrl !== 8'h00) begin errors++; $display("FAIL divide_idle: got %b expected %b", ctrl, 8'h00); end
    checks++;
    if (stall_count !== 16'd3) begin errors++; $display("FAIL divide_count: got %0d expected 3", stall_count); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [4];
    seq[0] = 8'b1110_1011; seq[1] = 8'b1110_1001; seq[2] = 8'b1110_1001; seq[3] = 8'b0000_0001;
    do_reset();
    set_in(enc(5'd4, 1'b0, 4'd1, 4'd2, 4'd3), 1'b1, enc(5'd3, 1'b0, 4'd2, 4'd3, 4'd4), 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) ex_instr = of_instr;
      #1;
      checks++;
      if (ctrl !== seq[i % 4]) begin errors++; $display("FAIL b2b_cycle%0d: got %b expected %b", i, ctrl, seq[i % 4]); end
      tick();
    end
    checks++;
    if (stall_count !== 16'd6) begin errors++; $display("FAIL b2b_count: got %0d expected 6", stall_count); end
  endtask

  task automatic test_reset_mid_divide();
    do_reset();
    set_in('0, 1'b0, enc(5'd3, 1'b0, 4'd2, 4'd3, 4'd4), 1'b1, 1'b0);
    tick();
    tick();
    #1 reset_n = 1'b0;
    age = 0; exp_stall = 0; exp_flush = 0; exp_sat_stall = 0; exp_sat_flush = 0;
    #1;
    checks++;
    if (ctrl !== 8'h00) begin errors++; $display("FAIL midreset_ctrl: got %b expected %b", ctrl, 8'h00); end
    checks++;
    if (stall_count !== '0) begin errors++; $display("FAIL midreset_count: got %0d expected 0", stall_count); end
    tick();
    reset_n = 1'b1;
    #1;
    checks++;
    if (ctrl !== 8'b1110_1011) begin errors++; $display("FAIL midreset_restart: got %b expected %b", ctrl, 8'b1110_1011); end
    repeat (4) tick();
    checks++;
    if (ctrl !== 8'b1110_1011 || stall_count !== 16'd3) begin
      errors++; $display("FAIL midreset_complete: got %b/%0d expected %b/3", ctrl, stall_count, 8'b1110_1011);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    set_in('0, 1'b0, enc(5'd3, 1'b0, 4'd2, 4'd3, 4'd4), 1'b1, 1'b0);
    repeat (4) tick();
    checks++;
    if (s_stall_count !== 2'd3 || stall_count !== 16'd3) begin
      errors++; $display("FAIL sat_stall_first: got %0d/%0d expected 3/3", s_stall_count, stall_count);
    end
    repeat (4) tick();
    checks++;
    if (s_stall_count !== 2'd3 || stall_count !== 16'd6) begin
      errors++; $display("FAIL sat_stall_hold: got %0d/%0d expected 3/6", s_stall_count, stall_count);
    end
    set_in('0, 1'b0, enc(5'd18, 1'b0, 4'd0, 4'd0, 4'd0), 1'b1, 1'b1);
    repeat (5) tick();
    checks++;
    if (s_flush_count !== 2'd3 || flush_count !== 16'd5) begin
      errors++; $display("FAIL sat_flush_hold: got %0d/%0d expected 3/5", s_flush_count, flush_count);
    end
  endtask

  task automatic test_random();
    logic [7:0] e;
    logic [4:0] op;
    do_reset();
    set_in(rand_instr(), 1'b1, rand_instr(), 1'b1, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      #1;
      e = exp_ctrl(of_instr, of_valid, ex_instr, ex_valid, ex_branch_taken, age, reset_n);
      checks++;
      if (ctrl !== e) begin
        errors++; $display("FAIL random_ctrl[%0d]: got %b expected %b (of %h ex %h)", i, ctrl, e, of_instr, ex_instr);
      end
      tick();
      checks++;
      if (stall_count !== CNT_W'(exp_stall) || flush_count !== CNT_W'(exp_flush) ||
          s_stall_count !== SAT_W'(exp_sat_stall) || s_flush_count !== SAT_W'(exp_sat_flush)) begin
        errors++;
        $display("FAIL random_counts[%0d]: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d", i,
                 stall_count, flush_count, s_stall_count, s_flush_count,
                 exp_stall, exp_flush, exp_sat_stall, exp_sat_flush);
      end
      // Move instructions along the pipe as the expected controls dictate
      if (!e[5]) begin
        if (e[4]) ex_valid = 1'b0;
        else begin ex_instr = of_instr; ex_valid = of_valid; end
      end
      if (e[2]) begin of_instr = rand_instr(); of_valid = 1'b0; end
      else if (!e[6]) begin of_instr = rand_instr(); of_valid = ($urandom_range(0, 9) != 0); end
      op = ex_instr[31:27];
      ex_branch_taken = ex_valid && (op >= 5'd16) && (op <= 5'd20) && ($urandom_range(0, 2) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch();
    test_divide();
    test_back_to_back();
    test_reset_mid_divide();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
